// File: rtl/shift_add_mul4_pkg.sv
// Shared definitions for the shift-and-add multiplier.
// Holds the default operand width, the controller state encoding and a
// helper that sizes the iteration counter for a given operand width.
package shift_add_mul4_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  // One extra bit beyond $clog2 so the counter can represent WIDTH itself.
  function automatic int cntWidth(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/shift_add_mul4_if.sv
// Request/result bundle for the shift-and-add multiplier.
//   start_i : request to begin one multiplication (sampled only when idle)
//   a_i     : multiplicand, unsigned, WIDTH bits
//   b_i     : multiplier, unsigned, WIDTH bits
//   busy_o  : high whenever the multiplier is not idle
//   done_o  : one-cycle pulse, p_o valid while high
//   p_o     : unsigned product, 2*WIDTH bits, held between operations
// master drives the request side, slave is the multiplier itself.
interface shift_add_mul4_if #(
  parameter int WIDTH = shift_add_mul4_pkg::DEFAULT_WIDTH
);

  logic                 start_i;
  logic [WIDTH-1:0]     a_i;
  logic [WIDTH-1:0]     b_i;
  logic                 busy_o;
  logic                 done_o;
  logic [2*WIDTH-1:0]   p_o;

  modport master (
    output start_i, a_i, b_i,
    input  busy_o, done_o, p_o
  );

  modport slave (
    input  start_i, a_i, b_i,
    output busy_o, done_o, p_o
  );

endinterface

// File: rtl/shift_add_mul4_adder_w.sv
// Purely combinational WIDTH-bit ripple adder used by the multiplier datapath.
//   a_i, b_i : WIDTH-bit addends
//   cin_i    : carry in
//   f_o      : WIDTH-bit sum
//   cout_o   : carry out
module adder_w #(
  parameter int WIDTH = shift_add_mul4_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] f_o,
  output logic             cout_o
);

  assign {cout_o, f_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/shift_add_mul4.sv
// Sequential unsigned multiplier using the classic shift-and-add scheme.
// One partial product is accumulated per CALC cycle, so a product takes
// WIDTH cycles of arithmetic plus one FIN cycle that presents DONE.
//   clk_i : rising-edge clock for all state
//   rst_i : synchronous active-high reset, overrides everything
//   bus   : slave side of shift_add_mul4_if (start/a/b in, busy/done/p out)
module shift_add_mul4
  import shift_add_mul4_pkg::*;
#(
  parameter int WIDTH = shift_add_mul4_pkg::DEFAULT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  shift_add_mul4_if.slave        bus
);

  localparam int CNT_W = cntWidth(WIDTH);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 carry;
  logic [2*WIDTH-1:0]   accNext;
  logic                 acc_lsb_unused;

  // The upper half of the accumulator absorbs the current partial product.
  assign addend = mplier_q[0] ? mcand_q : '0;

  adder_w #(.WIDTH(WIDTH)) u_adder (
    .a_i    (acc_q[2*WIDTH-1:WIDTH]),
    .b_i    (addend),
    .cin_i  (1'b0),
    .f_o    (sum),
    .cout_o (carry)
  );

  // Shift right by one while keeping the adder carry as the new MSB;
  // the accumulator LSB falls off the end by design.
  assign accNext        = {carry, sum, acc_q[WIDTH-1:1]};
  assign acc_lsb_unused = acc_q[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    p_d      = p_q;

    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          mcand_d  = bus.a_i;
          mplier_d = bus.b_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end

      CALC: begin
        acc_d    = accNext;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        // Last iteration: publish the finished accumulator directly.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          p_d     = accNext;
          state_d = FIN;
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy_o = (state_q != IDLE);
  assign bus.done_o = (state_q == FIN);
  assign bus.p_o    = p_q;

endmodule

// File: tb/tb_shift_add_mul4.sv
// Self-checking bench for shift_add_mul4 (WIDTH=4).
// Expected products are pushed to a queue when an operation is launched and
// popped when DONE is observed. Inputs change and outputs are sampled 1ns
// after each rising clock edge.
module tb_shift_add_mul4;

  localparam int W = 4;
  typedef logic [2*W-1:0] prod_t;

  logic clk;
  logic rst;

  shift_add_mul4_if #(.WIDTH(W)) bus ();

  shift_add_mul4 #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    nCompared   = 0;
  int    nMismatched = 0;
  prod_t expQ[$];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.a_i     = a;
    bus.b_i     = b;
    bus.start_i = 1'b1;
    stepCycle();
    bus.start_i = 1'b0;
  endtask

  // Bounded wait for DONE; reports how many edges it took.
  task automatic waitDone(output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      stepCycle();
      cycles++;
      if (bus.done_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  function automatic prod_t popExp();
    if (expQ.size() > 0) return expQ.pop_front();
    return 'x;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.a_i = '0;
    bus.b_i = '0;
    stepCycle();
    stepCycle();
    nCompared++;
    if (bus.busy_o !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_busy: got %b required 0", bus.busy_o);
    end
    nCompared++;
    if (bus.done_o !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_done: got %b required 0", bus.done_o);
    end
    nCompared++;
    if (bus.p_o !== prod_t'(0)) begin
      nMismatched++;
      $display("[TB] FAIL reset_p: got %0d required 0", bus.p_o);
    end
    rst = 1'b0;
    stepCycle();
    nCompared++;
    if (bus.busy_o !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL idle_hold_busy: got %b required 0", bus.busy_o);
    end
  endtask

  task automatic test_basic();
    int    cycles;
    int    busyCount;
    bit    seen;
    prod_t exp;
    expQ.push_back(prod_t'(3 * 5));
    pulseStart(4'd3, 4'd5);
    busyCount = (bus.busy_o === 1'b1) ? 1 : 0;
    cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      stepCycle();
      cycles++;
      if (bus.busy_o === 1'b1) busyCount++;
      if (bus.done_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    nCompared++;
    if (!seen || cycles != W) begin
      nMismatched++;
      $display("[TB] FAIL basic_latency: got seen=%0d after %0d edges required DONE after %0d edges", seen, cycles, W);
    end
    exp = popExp();
    nCompared++;
    if (bus.p_o !== exp) begin
      nMismatched++;
      $display("[TB] FAIL basic_p: got %0d required %0d", bus.p_o, exp);
    end
    stepCycle();
    if (bus.busy_o === 1'b1) busyCount++;
    nCompared++;
    if (busyCount != W + 1) begin
      nMismatched++;
      $display("[TB] FAIL basic_busy_len: got %0d cycles required %0d", busyCount, W + 1);
    end
    nCompared++;
    if (bus.done_o !== 1'b0 || bus.p_o !== exp) begin
      nMismatched++;
      $display("[TB] FAIL basic_after: got done=%b p=%0d required done=0 p=%0d", bus.done_o, bus.p_o, exp);
    end
  endtask

  task automatic test_carry();
    int    cycles;
    bit    seen;
    prod_t exp;
    expQ.push_back(prod_t'(15 * 15));
    pulseStart(4'd15, 4'd15);
    waitDone(cycles, seen);
    exp = popExp();
    nCompared++;
    if (!seen || bus.p_o !== exp) begin
      nMismatched++;
      $display("[TB] FAIL carry_p: got seen=%0d p=%0d required p=%0d", seen, bus.p_o, exp);
    end
    stepCycle();
  endtask

  task automatic test_zero();
    int    cycles;
    int    extraDone;
    bit    seen;
    prod_t exp;
    logic [W-1:0] aVals[2] = '{4'd0, 4'd9};
    logic [W-1:0] bVals[2] = '{4'd9, 4'd0};
    for (int k = 0; k < 2; k++) begin
      expQ.push_back(prod_t'(aVals[k] * bVals[k]));
      pulseStart(aVals[k], bVals[k]);
      waitDone(cycles, seen);
      exp = popExp();
      nCompared++;
      if (!seen || bus.p_o !== exp) begin
        nMismatched++;
        $display("[TB] FAIL zero_p%0d: got seen=%0d p=%0d required p=%0d", k, seen, bus.p_o, exp);
      end
      extraDone = 0;
      for (int i = 0; i < 8; i++) begin
        stepCycle();
        if (bus.done_o !== 1'b0) extraDone++;
      end
      nCompared++;
      if (extraDone != 0) begin
        nMismatched++;
        $display("[TB] FAIL zero_single_done%0d: got %0d extra DONE cycles required 0", k, extraDone);
      end
    end
  endtask

  task automatic test_ignore_start();
    int    cycles;
    int    extraDone;
    bit    seen;
    prod_t exp;
    expQ.push_back(prod_t'(1 * 10));
    pulseStart(4'd1, 4'd10);
    stepCycle();
    // Second CALC cycle: new request and new operands must be ignored.
    pulseStart(4'd7, 4'd7);
    waitDone(cycles, seen);
    exp = popExp();
    nCompared++;
    if (!seen || bus.p_o !== exp) begin
      nMismatched++;
      $display("[TB] FAIL ignore_p: got seen=%0d p=%0d required p=%0d", seen, bus.p_o, exp);
    end
    extraDone = 0;
    for (int i = 0; i < 12; i++) begin
      stepCycle();
      if (bus.done_o !== 1'b0) extraDone++;
    end
    nCompared++;
    if (extraDone != 0 || bus.busy_o !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL ignore_no_second: got extraDone=%0d busy=%b required 0 and 0", extraDone, bus.busy_o);
    end
  endtask

  task automatic test_reset_mid();
    int    cycles;
    int    lateDone;
    bit    seen;
    prod_t exp;
    expQ.push_back(prod_t'(6 * 7));
    pulseStart(4'd6, 4'd7);
    stepCycle();
    stepCycle();
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    void'(expQ.pop_back());
    nCompared++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.p_o !== prod_t'(0)) begin
      nMismatched++;
      $display("[TB] FAIL midreset_clear: got busy=%b done=%b p=%0d required 0 0 0", bus.busy_o, bus.done_o, bus.p_o);
    end
    lateDone = 0;
    for (int i = 0; i < 6; i++) begin
      stepCycle();
      if (bus.done_o !== 1'b0) lateDone++;
    end
    nCompared++;
    if (lateDone != 0) begin
      nMismatched++;
      $display("[TB] FAIL midreset_no_done: got %0d DONE cycles required 0", lateDone);
    end
    expQ.push_back(prod_t'(6 * 7));
    pulseStart(4'd6, 4'd7);
    waitDone(cycles, seen);
    exp = popExp();
    nCompared++;
    if (!seen || bus.p_o !== exp) begin
      nMismatched++;
      $display("[TB] FAIL midreset_fresh_p: got seen=%0d p=%0d required p=%0d", seen, bus.p_o, exp);
    end
    stepCycle();
  endtask

  task automatic test_back_to_back();
    int    cycles;
    int    lastDone;
    int    doneCount;
    bit    seen;
    prod_t exp;
    bus.a_i = 4'd2;
    bus.b_i = 4'd3;
    bus.start_i = 1'b1;
    lastDone = -1;
    doneCount = 0;
    for (int i = 0; i < 20; i++) begin
      // An idle multiplier with START high accepts at this edge.
      if (bus.busy_o === 1'b0) expQ.push_back(prod_t'(2 * 3));
      stepCycle();
      if (bus.done_o === 1'b1) begin
        exp = popExp();
        nCompared++;
        if (bus.p_o !== exp) begin
          nMismatched++;
          $display("[TB] FAIL b2b_p%0d: got %0d required %0d", doneCount, bus.p_o, exp);
        end
        if (lastDone >= 0) begin
          nCompared++;
          if (i - lastDone != W + 2) begin
            nMismatched++;
            $display("[TB] FAIL b2b_period: got %0d cycles required %0d", i - lastDone, W + 2);
          end
        end
        lastDone = i;
        doneCount++;
      end
    end
    bus.start_i = 1'b0;
    nCompared++;
    if (doneCount != 3) begin
      nMismatched++;
      $display("[TB] FAIL b2b_count: got %0d DONE pulses required 3", doneCount);
    end
    waitDone(cycles, seen);
    exp = popExp();
    nCompared++;
    if (!seen || bus.p_o !== exp) begin
      nMismatched++;
      $display("[TB] FAIL b2b_last_p: got seen=%0d p=%0d required p=%0d", seen, bus.p_o, exp);
    end
    nCompared++;
    if (expQ.size() != 0) begin
      nMismatched++;
      $display("[TB] FAIL b2b_queue: got %0d pending results required 0", expQ.size());
    end
    stepCycle();
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.a_i = '0;
    bus.b_i = '0;
    test_reset();
    test_basic();
    test_carry();
    test_zero();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/shift_add_mul4.md
SHIFT_ADD_MUL4 -- requirements
Module: shift_add_mul4

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; all widths below are in terms of WIDTH.
REQ-002 Clocking and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-003 CLK  input  1  rising-edge clock for all state.
REQ-004 RST  input  1  synchronous active-high reset.
REQ-005 START  input  1  request to begin one multiplication; sampled only in IDLE.
REQ-006 A  input  WIDTH  multiplicand, unsigned; captured on accepted START.
REQ-007 B  input  WIDTH  multiplier, unsigned; captured on accepted START.
REQ-008 BUSY  output  1  high in any state other than IDLE.
REQ-009 DONE  output  1  one-cycle pulse; P is valid while it is high.
REQ-010 P  output  2*WIDTH  unsigned product A*B; holds its value until the next accepted START.

Function
REQ-011 FSM SHALL have exactly three states: IDLE, CALC, FIN.
REQ-012 IDLE with START=1 at an edge SHALL capture A into MCAND and B into MPLIER, clear ACC (2*WIDTH) and CNT, and go to CALC.
REQ-013 IDLE with START=0 SHALL stay in IDLE and hold every register.
REQ-014 Each CALC cycle SHALL form {carry, sum} = ACC[2W-1:W] + (MPLIER[0] ? MCAND : 0) through one WIDTH-bit adder with carry-in tied to 0.
REQ-015 At the end of each CALC cycle, ACC SHALL load {carry, sum, ACC[W-1:1]}, MPLIER SHALL shift right by 1, and CNT SHALL increment.
REQ-016 The adder carry-out SHALL never be discarded; ACC bit 2W-1 receives it.
REQ-017 CALC SHALL run exactly WIDTH cycles; the edge ending cycle WIDTH SHALL load P from the final ACC value and enter FIN.
REQ-018 FIN SHALL assert DONE for exactly one cycle and return to IDLE at the next edge unconditionally.
REQ-019 Latency: if START is accepted at edge k, DONE SHALL be high during the cycle following edge k+WIDTH; the sustained rate is one result per WIDTH+2 cycles.
REQ-020 START while in CALC or FIN SHALL be ignored; operands and progress are unaffected.
REQ-021 A or B changing after acceptance SHALL NOT affect the result.
REQ-022 START held high continuously SHALL start a new operation at the first IDLE edge after FIN.
REQ-023 Boundary values: A=0 or B=0 gives P=0; A=B=2^W-1 gives P=(2^W-1)^2 with no overflow.

Reset
REQ-024 RST=1 at an edge SHALL force IDLE and clear BUSY=0, DONE=0, P=0, ACC=0, MCAND=0, MPLIER=0 and CNT=0.
REQ-025 RST SHALL take priority over START and over any in-progress operation; a partial result is discarded.
REQ-026 No output SHALL change asynchronously to CLK.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE/CALC/FIN) and the default WIDTH constant.
REQ-028 The adder SHALL be a separate combinational sub-module, adder_w (WIDTH-bit A, B and CIN; outputs F and COUT), instantiated once.
REQ-029 CNT SHALL be $clog2(WIDTH)+1 bits wide.
REQ-030 BUSY SHALL be decoded from the state register.
REQ-031 DONE SHALL be decoded from the state register (state==FIN).

Verification
REQ-032 A=3, B=5, one START pulse -> DONE 5 cycles after acceptance (WIDTH=4); P=15 (0x0F); BUSY high for 5 cycles.
REQ-033 A=15, B=15 -> P=225 (0xE1); exercises the carry-out path.
REQ-034 A=0, B=9, then A=9, B=0 -> P=0 both times; DONE pulses once per operation.
REQ-035 Start A=1, B=10; pulse START with A=7, B=7 in cycle 2 of CALC -> result is P=10; no second DONE follows.
REQ-036 Assert RST in the 3rd CALC cycle of 6*7 -> next cycle BUSY=0, DONE=0, P=0; a fresh 6*7 then gives P=42.
REQ-037 START held high for 20 cycles with A=2, B=3 -> DONE pulses every 6 cycles, P=6 each time.
